// File: rtl/rv32_dma_engine.sv
// Single-channel DMA engine between a SoC SRAM port and a valid/ready stream.
// Latency: decision one cycle after cfg_start; read = 2 cycles/word (req, out); write = 1 cycle/word.
// Backpressure: dma_grant low holds every state; m_out_ready low holds the output word; s_in_valid gates writes.
//
// Optional feature: define DMA_FAIRNESS_EN to release the SoC port for one cycle
// after every 4 consecutive granted bus cycles.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   cfg_start/dir/addr/len/abort  transfer control (start is a 1-cycle pulse)
//   busy, done_irq, err           status: non-idle, 1-cycle completion, sticky misalignment error
//   dma_req/addr/wdata/we         SoC DMA port request side
//   dma_rdata, dma_grant          SoC DMA port response (grant is combinational)
//   m_out_valid/data/ready        read-mode output stream
//   s_in_valid/data/ready         write-mode input stream
module rv32_dma_engine #(
  parameter int XLEN  = 32,
  parameter int LEN_W = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_dir,
  input  logic [XLEN-1:0]  cfg_addr,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_abort,
  output logic             busy,
  output logic             done_irq,
  output logic             err,
  output logic             dma_req,
  output logic [XLEN-1:0]  dma_addr,
  output logic [XLEN-1:0]  dma_wdata,
  output logic             dma_we,
  input  logic [XLEN-1:0]  dma_rdata,
  input  logic             dma_grant,
  output logic             m_out_valid,
  output logic [XLEN-1:0]  m_out_data,
  input  logic             m_out_ready,
  input  logic             s_in_valid,
  input  logic [XLEN-1:0]  s_in_data,
  output logic             s_in_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_OUT  = 3'd2,
    WR_XFER = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state;
  logic [XLEN-1:0]  addr;
  logic [LEN_W-1:0] count;
  logic             throttle;
  logic             req_raw;
  logic             xfer;
  logic [XLEN-1:0]  addr_next;

  // Only the 64 KiB window offset advances; the page bits and the byte
  // offset stay put, so a transfer wraps inside its 64 KiB page.
  assign addr_next = {addr[XLEN-1:16], addr[15:2] + 14'd1, addr[1:0]};

`ifdef DMA_FAIRNESS_EN
  // Length of the current run of back-to-back granted bus cycles.
  logic [2:0] run_cnt;

  assign throttle = (run_cnt == 3'd4);

  // A throttled cycle has no transfer, so the run restarts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= 3'd0;
    end else if (xfer) begin
      run_cnt <= run_cnt + 3'd1;
    end else begin
      run_cnt <= 3'd0;
    end
  end
`else
  assign throttle = 1'b0;
`endif

  // Abort removes the request in the same cycle so it wins over a
  // simultaneous grant: nothing moves on the bus while aborting.
  assign req_raw     = (state == RD_REQ) || ((state == WR_XFER) && s_in_valid);
  assign dma_req     = req_raw && !throttle && !cfg_abort;
  assign xfer        = dma_req && dma_grant;
  assign dma_we      = (state == WR_XFER);
  assign dma_wdata   = dma_we ? s_in_data : '0;
  assign s_in_ready  = dma_we && xfer;
  assign dma_addr    = addr;
  assign m_out_valid = (state == RD_OUT) && !cfg_abort;
  assign busy        = (state != IDLE);
  assign done_irq    = (state == DONE) && !cfg_abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      count      <= '0;
      m_out_data <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            addr  <= cfg_addr;
            count <= cfg_len;
            err   <= (cfg_addr[1:0] != 2'b00);
            if (cfg_addr[1:0] != 2'b00) begin
              state <= DONE;
            end else if (cfg_len == '0) begin
              state <= DONE;
            end else if (cfg_dir) begin
              state <= WR_XFER;
            end else begin
              state <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (cfg_abort) begin
            state <= IDLE;
          end else if (xfer) begin
            m_out_data <= dma_rdata;
            addr       <= addr_next;
            count      <= count - LEN_W'(1);
            state      <= RD_OUT;
          end
        end
        RD_OUT: begin
          if (cfg_abort) begin
            state <= IDLE;
          end else if (m_out_ready) begin
            state <= (count == '0) ? DONE : RD_REQ;
          end
        end
        WR_XFER: begin
          if (cfg_abort) begin
            state <= IDLE;
          end else if (xfer) begin
            addr  <= addr_next;
            count <= count - LEN_W'(1);
            if (count == LEN_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_dma_engine.sv
module tb_rv32_dma_engine;
  localparam int XLEN  = 32;
  localparam int LEN_W = 15;
`ifdef DMA_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_start, cfg_dir, cfg_abort;
  logic [XLEN-1:0]  cfg_addr;
  logic [LEN_W-1:0] cfg_len;
  logic             busy, done_irq, err;
  logic             dma_req, dma_we, dma_grant;
  logic [XLEN-1:0]  dma_addr, dma_wdata, dma_rdata;
  logic             m_out_valid, m_out_ready;
  logic [XLEN-1:0]  m_out_data;
  logic             s_in_valid, s_in_ready;
  logic [XLEN-1:0]  s_in_data;

  always #5 clk = ~clk;

  rv32_dma_engine #(.XLEN(XLEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_dir(cfg_dir), .cfg_addr(cfg_addr),
    .cfg_len(cfg_len), .cfg_abort(cfg_abort),
    .busy(busy), .done_irq(done_irq), .err(err),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_we(dma_we), .dma_rdata(dma_rdata), .dma_grant(dma_grant),
    .m_out_valid(m_out_valid), .m_out_data(m_out_data), .m_out_ready(m_out_ready),
    .s_in_valid(s_in_valid), .s_in_data(s_in_data), .s_in_ready(s_in_ready)
  );

  // SRAM model: one word per 4-byte slot of the 64 KiB window.
  logic [31:0] mem [0:16383];
  assign dma_rdata = mem[dma_addr[15:2]];

  int total = 0;
  int bad   = 0;

  // Per-transfer observations for the directed scenarios.
  int r_done, r_done_cyc, r_req, r_busy, r_stall, r_stall_req, r_end;
  bit req_pat[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // Byte address of word i of a transfer: low 16 bits count up by 4 and wrap.
  function automatic logic [31:0] word_addr(input logic [31:0] a, input int i);
    logic [15:0] lo;
    lo = a[15:0] + 16'(4 * i);
    return {a[31:16], lo};
  endfunction

  task automatic run_xfer(input bit dir, input logic [31:0] addr, input int len,
                          input int gp, input int rp, input int vp,
                          input int abort_at, input int exp_override,
                          input bit stall2, input bit junk);
    logic [31:0] words[$];
    logic [31:0] a_q[$];
    logic [31:0] w_q[$];
    logic [31:0] o_q[$];
    logic [31:0] prev_out = '0;
    logic [31:0] ea;
    int wi = 0, consumed = 0, inv = 0, stall_left = 5, exp_n;
    bit hs_prev = 0, prev_stall = 0, finished = 0, misal;

    misal = (addr[1:0] != 2'b00);
    exp_n = (exp_override >= 0) ? exp_override : (misal ? 0 : len);
    for (int i = 0; i < len; i++) words.push_back($urandom);
    r_done = 0; r_done_cyc = -1; r_req = 0; r_busy = 0;
    r_stall = 0; r_stall_req = 0; r_end = -1;
    req_pat.delete();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      if (hs_prev) wi++;
      cfg_start = (cyc == 0);
      if (cyc == 0) begin
        cfg_dir  = dir;
        cfg_addr = addr;
        cfg_len  = LEN_W'(len);
      end else if (junk && busy && pct(25)) begin
        cfg_start = 1'b1;
        cfg_dir   = 1'($urandom);
        cfg_addr  = $urandom;
        cfg_len   = LEN_W'($urandom);
      end
      cfg_abort = (cyc == abort_at);
      dma_grant = pct(gp);
      if (dir) s_in_valid = (wi < words.size()) && pct(vp);
      else     s_in_valid = pct(50);
      s_in_data = (dir && wi < words.size()) ? words[wi] : $urandom;
      if (stall2 && o_q.size() == 1 && m_out_valid && stall_left > 0) begin
        m_out_ready = 1'b0;
        stall_left--;
      end else begin
        m_out_ready = pct(rp);
      end

      #3;
      if (dma_req && dma_grant) begin
        a_q.push_back(dma_addr);
        if (dma_we) begin
          w_q.push_back(dma_wdata);
          mem[dma_addr[15:2]] = dma_wdata;
        end
      end
      if (busy && !done_irq) begin
        r_busy++;
        req_pat.push_back(dma_req);
      end
      if (dma_req) r_req++;
      if (done_irq) begin
        r_done++;
        r_done_cyc = cyc;
      end
      if (dma_req && !busy) inv++;
      if (!dma_we && (s_in_ready || dma_wdata != '0)) inv++;
      if (dma_we && (dma_wdata !== s_in_data || s_in_ready !== (dma_req && dma_grant)
                     || (dma_req && !s_in_valid))) inv++;
      if (m_out_valid && dma_req) inv++;
      if (prev_stall && cyc != abort_at && (!m_out_valid || m_out_data !== prev_out)) inv++;
      if (m_out_valid && !m_out_ready) begin
        r_stall++;
        if (dma_req) r_stall_req++;
      end
      prev_stall = m_out_valid && !m_out_ready;
      prev_out   = m_out_data;
      if (m_out_valid && m_out_ready) o_q.push_back(m_out_data);
      hs_prev = s_in_valid && s_in_ready;
      if (hs_prev) consumed++;
      if (cyc >= 1 && !busy) begin
        finished = 1;
        r_end = cyc;
        break;
      end
    end

    check("finished", 32'(finished), 32'd1);
    check("done_cnt", r_done, (abort_at >= 0) ? 0 : 1);
    check("err", 32'(err), 32'(misal));
    check("bus_n", a_q.size(), exp_n);
    check("consumed", consumed, dir ? exp_n : 0);
    check("out_n", o_q.size(), dir ? 0 : exp_n);
    for (int i = 0; i < a_q.size() && i < exp_n; i++)
      check("addr", a_q[i], word_addr(addr, i));
    for (int i = 0; i < w_q.size() && i < exp_n; i++)
      check("wdata", w_q[i], words[i]);
    for (int i = 0; i < o_q.size() && i < exp_n; i++) begin
      ea = word_addr(addr, i);
      check("rdata", o_q[i], mem[ea[15:2]]);
    end
    check("invariants", inv, 0);
  endtask

  initial begin
    bit exp_pat[$];
    int left, run, dn;
    logic [31:0] ra;

    rst = 1'b0;
    cfg_start = 0; cfg_dir = 0; cfg_addr = '0; cfg_len = '0; cfg_abort = 0;
    dma_grant = 0; m_out_ready = 0; s_in_valid = 0; s_in_data = '0;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    mem[64] = 32'hAAAA_0001;
    mem[65] = 32'hBBBB_0002;
    mem[66] = 32'hCCCC_0003;
    mem[67] = 32'hDDDD_0004;
    #1 rst = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done_irq), 0);
    check("rst_err", 32'(err), 0);
    check("rst_req", 32'(dma_req), 0);
    check("rst_addr", dma_addr, 0);
    check("rst_we", 32'(dma_we), 0);
    check("rst_wdata", dma_wdata, 0);
    check("rst_mvalid", 32'(m_out_valid), 0);
    check("rst_mdata", m_out_data, 0);
    check("rst_sready", 32'(s_in_ready), 0);
    rst = 1'b0;

    // Read A,B,C,D from 0x100: two cycles per word in the read states
    run_xfer(0, 32'h100, 4, 100, 100, 0, -1, -1, 0, 0);
    check("rd4_cycles", r_busy, 8);
    check("rd4_done_cyc", r_done_cyc, 9);

    // Write across the 64 KiB wrap, then read the same words back
    run_xfer(1, 32'hFFF8, 4, 100, 100, 100, -1, -1, 0, 0);
    check("wr_wrap_cycles", r_busy, 4);
    run_xfer(0, 32'hFFF8, 4, 100, 100, 0, -1, -1, 0, 0);

    // Misaligned start: error, immediate completion, no bus traffic
    run_xfer(1, 32'h102, 4, 100, 100, 100, -1, -1, 0, 0);
    check("misal_done_cyc", r_done_cyc, 1);
    check("misal_req", r_req, 0);
    // Zero length: completion, error cleared
    run_xfer(0, 32'h200, 0, 100, 100, 0, -1, -1, 0, 0);
    check("len0_done_cyc", r_done_cyc, 1);
    check("len0_req", r_req, 0);

    // Output stall of 5 cycles on the second word
    run_xfer(0, 32'h300, 3, 100, 100, 0, -1, -1, 1, 0);
    check("stall_cycles", r_stall, 5);
    check("stall_req", r_stall_req, 0);

    // Abort in the second write cycle: one word written, no completion
    run_xfer(1, 32'h400, 4, 100, 100, 100, 2, 1, 0, 0);
    check("abort_idle_cyc", r_end, 3);
    run_xfer(1, 32'h500, 2, 100, 100, 100, -1, -1, 0, 0);

    // Request pattern for a 10-word write under constant grant
    run_xfer(1, 32'h600, 10, 100, 100, 100, -1, -1, 0, 0);
    left = 10;
    run  = 0;
    while (left > 0) begin
      if (FAIR && run == 4) begin
        exp_pat.push_back(1'b0);
        run = 0;
      end else begin
        exp_pat.push_back(1'b1);
        run++;
        left--;
      end
    end
    check("pat_len", req_pat.size(), exp_pat.size());
    for (int i = 0; i < req_pat.size() && i < exp_pat.size(); i++)
      check("pat_bit", 32'(req_pat[i]), 32'(exp_pat[i]));

    // Reset in the middle of a read
    @(posedge clk);
    #1;
    cfg_start = 1; cfg_dir = 0; cfg_addr = 32'h800; cfg_len = LEN_W'(8);
    dma_grant = 1; m_out_ready = 1; cfg_abort = 0;
    @(posedge clk);
    #1;
    cfg_start = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #3;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_req", 32'(dma_req), 0);
    check("mrst_addr", dma_addr, 0);
    check("mrst_mvalid", 32'(m_out_valid), 0);
    check("mrst_mdata", m_out_data, 0);
    check("mrst_done", 32'(done_irq), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #4;
      if (done_irq || busy) dn++;
    end
    check("mrst_quiet", dn, 0);

    // Randomized transfers against the reference model
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      ra[1:0] = 2'b00;
      if (pct(12)) ra[1:0] = 2'(1 + $urandom_range(2));
      if (pct(25)) ra[15:0] = 16'hFFE0 | 16'(ra[4:0]);
      run_xfer(1'($urandom), ra, int'($urandom_range(20)),
               30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)),
               30 + int'($urandom_range(70)), -1, -1, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
